peak_counter_gated_multi: RTL
=============================

// Module: peak_counter_gated_multi
// PURPOSE
//  NUM_CH-channel gated peak counter. Synchronises each sig_in bit, detects the selected edge
//  and counts edges per channel over a programmable gate window of clken cycles. At window
//  end, all channel counts and overflow flags are snapshotted together and live counters clear.
//  Snapshots are read one channel at a time through a registered mux for the host interface.
// PARAMETERS
//  NUM_CH      4   number of input channels (1..16)
//  CNTR_WIDTH  16  per-channel counter width
//  GATE_WIDTH  24  gate-length timer width
//  SATURATE    0   0: wrap to 0 on overflow; 1: hold at MAXCOUNT on overflow
// PORTS
//  clk         in   1              system clock, all logic on posedge
//  rst         in   1              asynchronous, active-high reset
//  clken       in   1              sample/count enable; all state except readout advances only when 1
//  sig_in      in   NUM_CH         asynchronous peak inputs, one bit per channel
//  edge_mode   in   2              00 rise, 01 fall, 10 both, 11 rise (reserved)
//  gate_len    in   GATE_WIDTH     window length in clken cycles; 0 treated as 1
//  start       in   1              pulse: arm and begin windows
//  stop        in   1              pulse: abort current window
//  continuous  in   1              1: auto-restart windows; 0: single window
//  busy        out  1              1 while in RUN
//  snap_valid  out  1              one-clk pulse when a new snapshot is loaded
//  rd_sel      in   $clog2(NUM_CH) channel select for readout (min width 1)
//  rd_count    out  CNTR_WIDTH     snapshot count of rd_sel channel, registered
//  rd_ovf      out  1              snapshot overflow flag of rd_sel channel, registered
// BEHAVIOUR
//  Reset: all sync/edge regs, live counters, ovf flags, snapshots, timer, busy, snap_valid,
//   rd_count, rd_ovf <= 0; FSM -> IDLE. Reset mid-window discards everything; no snapshot.
//  Sync/edge (per ch, on clken): s1<=sig_in, s2<=s1, s3<=s2. rise=s2&~s3, fall=~s2&s3.
//   An input level change sampled at clken cycle k is counted at the clken edge k+2.
//  FSM IDLE: start=1 -> RUN, timer<=0, live counters/ovf <= 0. stop ignored.
//  FSM RUN: busy=1. Each clken cycle, timer++. Edge on a channel -> live count +1.
//   Count at MAXCOUNT (2**CNTR_WIDTH-1) + edge -> ovf sticky set; count wraps to 0
//   (SATURATE=0) or holds at MAXCOUNT (SATURATE=1).
//  Window end: clken=1 and timer==max(gate_len,1)-1. Snapshot <= count/ovf including this
//   cycle's edge. Live counters/ovf <= 0. timer <= 0. snap_valid=1 next clk, one cycle only.
//   Then continuous=1 -> stay RUN; continuous=0 -> IDLE.
//  stop=1 in RUN: -> IDLE next clk. Live counters cleared, no snapshot, old snapshot kept.
//   stop and window end in same cycle: stop wins, no snapshot.
//  start in RUN is ignored. start+stop in IDLE: start wins.
//  gate_len is sampled continuously; a change mid-window takes effect on the next compare.
//   Shrinking gate_len below the current timer ends the window when the timer wraps at
//   2**GATE_WIDTH; software changes gate_len only in IDLE.
//  Edges when clken=0 or in IDLE are not counted. Sync regs still track on clken in IDLE.
//  Readout: rd_count/rd_ovf <= snapshot[rd_sel] every clk, independent of clken; 1-clk
//   latency. rd_sel >= NUM_CH returns 0. Snapshot write and read in same clk return the old
//   value; the new value appears the following clk.
// TESTING
//  T1 clken=1, gate_len=100, rise, ch0 gets 10 pulses, single -> snap_valid once,
//   rd_sel=0 gives 10, ovf=0, busy drops.
//  T2 CNTR_WIDTH=4, 17 rises on ch1: SATURATE=0 -> count 1, ovf 1; SATURATE=1 -> 15, ovf 1.
//  T3 edge_mode=10, 5 full pulses on ch2 -> 10. edge_mode=01 -> 5. Edge on the last window
//   cycle lands in the closing snapshot, not the next window.
//  T4 continuous=1, gate_len=50, clken 1-in-3 -> snap_valid every 150 clk.
//   Per-window counts are independent, with no edge lost or double-counted at boundaries.
//  T5 stop at timer=30 -> IDLE, snapshot unchanged, no snap_valid.
//   stop and window end in the same cycle -> no snapshot.
//  T6 assert rst mid-window (async, between clk edges) -> all outputs 0 immediately.
//   start afterwards runs normally. gate_len=0 -> one-cycle windows.

Source files
------------

// File: rtl/peak_counter_gated_multi_if.sv
// Host-side bundle for the gated multi-channel peak counter: control, raw inputs and readout.
interface peak_counter_gated_multi_if #(
  parameter int NUM_CH     = 4,
  parameter int CNTR_WIDTH = 16,
  parameter int GATE_WIDTH = 24
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                  clken;
  logic [NUM_CH-1:0]     sig_in;
  logic [1:0]            edge_mode;
  logic [GATE_WIDTH-1:0] gate_len;
  logic                  start;
  logic                  stop;
  logic                  continuous;
  logic                  busy;
  logic                  snap_valid;
  logic [SEL_W-1:0]      rd_sel;
  logic [CNTR_WIDTH-1:0] rd_count;
  logic                  rd_ovf;

  modport master (
    output clken, sig_in, edge_mode, gate_len, start, stop, continuous, rd_sel,
    input  busy, snap_valid, rd_count, rd_ovf
  );

  modport slave (
    input  clken, sig_in, edge_mode, gate_len, start, stop, continuous, rd_sel,
    output busy, snap_valid, rd_count, rd_ovf
  );
endinterface

// File: rtl/peak_counter_gated_multi.sv
// NUM_CH-channel gated edge counter: per-channel sync/edge/count lanes, a shared gate FSM
// and timer, window-end snapshots and a registered readout mux.
module peak_counter_gated_multi_lane #(
  parameter int CNTR_WIDTH = 16,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic                  sig,
  input  logic [1:0]            edge_mode,
  input  logic                  run,
  input  logic                  clr,
  input  logic                  fire,
  output logic [CNTR_WIDTH-1:0] snap_cnt,
  output logic                  snap_ovf
);
  localparam logic [CNTR_WIDTH-1:0] MAXCOUNT = '1;

  logic [2:0]            sync;
  logic [CNTR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  ovf, ovf_nxt;
  logic                  rise, fall, hit;

  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];

  always_comb begin
    case (edge_mode)
      2'b01:   hit = fall;
      2'b10:   hit = rise | fall;
      default: hit = rise;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (hit) begin
      if (cnt == MAXCOUNT) begin
        ovf_nxt = 1'b1;
        cnt_nxt = (SATURATE != 0) ? MAXCOUNT : '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // The closing cycle's own edge goes into the snapshot via cnt_nxt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      snap_cnt <= '0;
      snap_ovf <= 1'b0;
    end else if (clken) begin
      sync <= {sync[1:0], sig};
      if (clr) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (fire) begin
        snap_cnt <= cnt_nxt;
        snap_ovf <= ovf_nxt;
        cnt      <= '0;
        ovf      <= 1'b0;
      end else if (run) begin
        cnt <= cnt_nxt;
        ovf <= ovf_nxt;
      end
    end
  end
endmodule

module peak_counter_gated_multi #(
  parameter int NUM_CH     = 4,
  parameter int CNTR_WIDTH = 16,
  parameter int GATE_WIDTH = 24,
  parameter int SATURATE   = 0
) (
  input logic                      clk,
  input logic                      rst,
  peak_counter_gated_multi_if.slave bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                               state, state_nxt;
  logic [GATE_WIDTH-1:0]                timer, timer_nxt, gl_m1;
  logic                                 clr, fire, run;
  logic [NUM_CH-1:0][CNTR_WIDTH-1:0]    snap_cnt;
  logic [NUM_CH-1:0]                    snap_ovf;
  logic [CNTR_WIDTH-1:0]                rd_cnt_mux;
  logic                                 rd_ovf_mux;

  assign gl_m1    = (bus.gate_len == '0) ? '0 : bus.gate_len - 1'b1;
  assign run      = (state == RUN);
  assign bus.busy = run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // stop outranks window end; start is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    clr       = 1'b0;
    fire      = 1'b0;
    if (bus.clken) begin
      case (state)
        IDLE: if (bus.start) begin
          state_nxt = RUN;
          timer_nxt = '0;
          clr       = 1'b1;
        end
        RUN: begin
          if (bus.stop) begin
            state_nxt = IDLE;
            timer_nxt = '0;
            clr       = 1'b1;
          end else if (timer == gl_m1) begin
            fire      = 1'b1;
            timer_nxt = '0;
            if (!bus.continuous) state_nxt = IDLE;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.snap_valid <= 1'b0;
    else     bus.snap_valid <= fire;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    peak_counter_gated_multi_lane #(
      .CNTR_WIDTH (CNTR_WIDTH),
      .SATURATE   (SATURATE)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .clken     (bus.clken),
      .sig       (bus.sig_in[i]),
      .edge_mode (bus.edge_mode),
      .run       (run),
      .clr       (clr),
      .fire      (fire),
      .snap_cnt  (snap_cnt[i]),
      .snap_ovf  (snap_ovf[i])
    );
  end

  // Unmatched selects (rd_sel >= NUM_CH) fall through to zero.
  always_comb begin
    rd_cnt_mux = '0;
    rd_ovf_mux = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_sel == SEL_W'(i)) begin
        rd_cnt_mux = snap_cnt[i];
        rd_ovf_mux = snap_ovf[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_count <= '0;
      bus.rd_ovf   <= 1'b0;
    end else begin
      bus.rd_count <= rd_cnt_mux;
      bus.rd_ovf   <= rd_ovf_mux;
    end
  end
endmodule
